// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared FSM state, frame constants and word type for spi_reg_arbiter
package spi_reg_pkg;

    typedef enum logic [1:0] {
        SKIP   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2,
        COMMIT = 2'd3
    } spi_state_t;

    localparam int FRAME_BITS  = 40;
    localparam int WR_FLAG_BIT = 7;
    localparam int IDX_W       = 4;
    localparam int BIT_CNT_W   = 6;

    typedef logic [31:0] reg_word_t;

endpackage

// File: rtl/spi_sync2.sv
// rtl/spi_sync2.sv - two-flop synchronizer for one raw SPI line
module spi_sync2 (
    input  logic Clk,
    input  logic Reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // Clearing to 0 keeps a chip select held low through reset from looking like a fresh idle period.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/spi_reg_arbiter.sv
// rtl/spi_reg_arbiter.sv - SPI frame committer and local writer sharing one register bank
// Optional bank watchdog is built in when SPI_REG_WDOG_EN is defined.
module spi_reg_arbiter
    import spi_reg_pkg::*;
#(
    parameter int NREG        = 16,
    parameter int WDOG_CYCLES = 50_000_000
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 SPI_CS,
    input  logic                 SPI_CLK,
    input  logic [7:0]           DataAddr,
    input  logic [31:0]          DataToFPGA,
    output logic [31:0]          DataToRPi,
    input  logic                 LocWrReq,
    input  logic [IDX_W-1:0]     LocWrAddr,
    input  logic [31:0]          LocWrData,
    output logic                 LocWrGnt,
    input  logic [IDX_W-1:0]     FpgaRdAddr,
    output logic [31:0]          FpgaRdData,
    output logic                 SpiWrStb,
    output logic [IDX_W-1:0]     SpiWrAddr,
    output logic [15:0]          FrameCnt,
    output logic [7:0]           ErrCnt,
    output logic                 WdogTrip
);

    if (NREG != (1 << IDX_W)) begin : g_bad_nreg
        $error("spi_reg_arbiter: NREG must equal 2**IDX_W");
    end
    if (WDOG_CYCLES < 2) begin : g_bad_wdog
        $error("spi_reg_arbiter: WDOG_CYCLES must be at least 2");
    end

    logic cs_sync, clk_sync, cs_prev, clk_prev;
    logic cs_rise, clk_rise;

    spi_sync2 u_sync_cs (
        .Clk      (Clk),
        .Reset    (Reset),
        .async_in (SPI_CS),
        .sync_out (cs_sync)
    );

    spi_sync2 u_sync_clk (
        .Clk      (Clk),
        .Reset    (Reset),
        .async_in (SPI_CLK),
        .sync_out (clk_sync)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cs_prev  <= 1'b0;
            clk_prev <= 1'b0;
        end else begin
            cs_prev  <= cs_sync;
            clk_prev <= clk_sync;
        end
    end

    assign cs_rise  = cs_sync & ~cs_prev;
    assign clk_rise = clk_sync & ~clk_prev;

    spi_state_t state, state_nxt;
    logic [BIT_CNT_W-1:0] bit_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= SKIP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SKIP:    if (cs_sync)  state_nxt = IDLE;
            IDLE:    if (!cs_sync) state_nxt = ACTIVE;
            ACTIVE:  if (cs_rise)  state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = SKIP;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset || state == IDLE) begin
            bit_cnt <= '0;
        end else if (state == ACTIVE && clk_rise && bit_cnt != '1) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    logic             in_commit, frame_good, is_wr, addr_ok;
    logic             spi_wr, spi_rd, frame_err, loc_gnt, wdog_fire;
    logic [IDX_W-1:0] spi_idx;

    assign in_commit  = (state == COMMIT);
    assign frame_good = (bit_cnt == BIT_CNT_W'(FRAME_BITS));
    assign is_wr      = DataAddr[WR_FLAG_BIT];
    assign addr_ok    = (DataAddr[WR_FLAG_BIT-1:IDX_W] == '0);
    assign spi_idx    = DataAddr[IDX_W-1:0];

    assign spi_wr    = in_commit & frame_good & is_wr & addr_ok;
    assign spi_rd    = in_commit & frame_good & ~is_wr;
    assign frame_err = in_commit & ~(frame_good & (~is_wr | addr_ok));

    // The SPI commit owns the bank port; a held local request simply lands one cycle later.
    assign loc_gnt  = LocWrReq & ~spi_wr & ~Reset;
    assign LocWrGnt = loc_gnt;

    reg_word_t bank [NREG];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) begin
                bank[i] <= '0;
            end
        end else begin
            if (spi_wr) begin
                bank[spi_idx] <= DataToFPGA;
            end else if (loc_gnt) begin
                bank[LocWrAddr] <= LocWrData;
            end
            // Placed last so the watchdog clear overrides a same-cycle local write to 0..3.
            if (wdog_fire) begin
                for (int i = 0; i < 4; i++) begin
                    bank[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            DataToRPi  <= '0;
            FpgaRdData <= '0;
            SpiWrStb   <= 1'b0;
            SpiWrAddr  <= '0;
            FrameCnt   <= '0;
            ErrCnt     <= '0;
        end else begin
            DataToRPi  <= bank[spi_idx];
            FpgaRdData <= bank[FpgaRdAddr];
            SpiWrStb   <= spi_wr;
            if (spi_wr) begin
                SpiWrAddr <= spi_idx;
            end
            if (spi_wr || spi_rd) begin
                FrameCnt <= FrameCnt + 16'd1;
            end
            if (frame_err && ErrCnt != 8'hFF) begin
                ErrCnt <= ErrCnt + 8'd1;
            end
        end
    end

`ifdef SPI_REG_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_PARK = WD_W'(WDOG_CYCLES);

    logic [WD_W-1:0] wdog_cnt;
    logic            wdog_trip_q;

    assign wdog_fire = ~spi_wr & (wdog_cnt == WD_LAST);

    // The counter parks one past the trip point so the bank is cleared once per silent period.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wdog_cnt    <= '0;
            wdog_trip_q <= 1'b0;
        end else if (spi_wr) begin
            wdog_cnt    <= '0;
            wdog_trip_q <= 1'b0;
        end else begin
            if (wdog_cnt != WD_PARK) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
            if (wdog_fire) begin
                wdog_trip_q <= 1'b1;
            end
        end
    end

    assign WdogTrip = wdog_trip_q;
`else
    assign wdog_fire = 1'b0;
    assign WdogTrip  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// tb/tb_spi_reg_arbiter.sv - scoreboard bench for spi_reg_arbiter (SPI_REG_WDOG_EN adds the watchdog case)
`timescale 1ns/1ps
module tb_spi_reg_arbiter;
    import spi_reg_pkg::*;

`ifdef SPI_REG_WDOG_EN
    localparam int WDOG       = 100;
    localparam bit WDOG_BUILD = 1'b1;
`else
    localparam int WDOG       = 1000;
    localparam bit WDOG_BUILD = 1'b0;
`endif

    logic        Clk, Reset, SPI_CS, SPI_CLK;
    logic [7:0]  DataAddr;
    logic [31:0] DataToFPGA, DataToRPi;
    logic        LocWrReq, LocWrGnt;
    logic [3:0]  LocWrAddr, FpgaRdAddr, SpiWrAddr;
    logic [31:0] LocWrData, FpgaRdData;
    logic        SpiWrStb, WdogTrip;
    logic [15:0] FrameCnt;
    logic [7:0]  ErrCnt;

    spi_reg_arbiter #(.NREG(16), .WDOG_CYCLES(WDOG)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .SPI_CS     (SPI_CS),
        .SPI_CLK    (SPI_CLK),
        .DataAddr   (DataAddr),
        .DataToFPGA (DataToFPGA),
        .DataToRPi  (DataToRPi),
        .LocWrReq   (LocWrReq),
        .LocWrAddr  (LocWrAddr),
        .LocWrData  (LocWrData),
        .LocWrGnt   (LocWrGnt),
        .FpgaRdAddr (FpgaRdAddr),
        .FpgaRdData (FpgaRdData),
        .SpiWrStb   (SpiWrStb),
        .SpiWrAddr  (SpiWrAddr),
        .FrameCnt   (FrameCnt),
        .ErrCnt     (ErrCnt),
        .WdogTrip   (WdogTrip)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] frame_cnt;
    } wr_exp_t;

    wr_exp_t exp_q[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Every SPI write strobe must match the next queued expectation.
    always @(negedge Clk) begin : mon
        wr_exp_t e;
        if (Reset === 1'b0 && SpiWrStb === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL spi_wr_unexpected: strobe at index %0d, expected none", SpiWrAddr);
            end else begin
                e = exp_q.pop_front();
                check32("spi_wr_addr", 32'(SpiWrAddr), 32'(e.addr));
                check32("spi_wr_frame_cnt", 32'(FrameCnt), 32'(e.frame_cnt));
            end
        end
    end

    task automatic clk_bits(input int n);
        for (int i = 0; i < n; i++) begin
            SPI_CLK = 1'b1;
            repeat (4) @(posedge Clk);
            #1;
            SPI_CLK = 1'b0;
            repeat (4) @(posedge Clk);
            #1;
        end
    endtask

    task automatic spi_frame(input logic [7:0] addr, input logic [31:0] data, input int nbits);
        @(posedge Clk);
        #1;
        DataAddr   = addr;
        DataToFPGA = data;
        SPI_CS     = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        clk_bits(nbits);
        SPI_CS = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
    endtask

    task automatic loc_write(input logic [3:0] a, input logic [31:0] d);
        @(posedge Clk);
        #1;
        LocWrAddr = a;
        LocWrData = d;
        LocWrReq  = 1'b1;
        @(negedge Clk);
        check32("loc_gnt", 32'(LocWrGnt), 32'd1);
        @(posedge Clk);
        #1;
        LocWrReq = 1'b0;
    endtask

    task automatic read_check(input logic [3:0] idx, input logic [31:0] exp, input string name);
        @(posedge Clk);
        #1;
        FpgaRdAddr = idx;
        @(posedge Clk);
        @(negedge Clk);
        check32(name, FpgaRdData, exp);
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        Reset      = 1'b1;
        SPI_CS     = 1'b1;
        SPI_CLK    = 1'b0;
        DataAddr   = 8'h00;
        DataToFPGA = '0;
        LocWrReq   = 1'b1;
        LocWrAddr  = 4'd9;
        LocWrData  = 32'hFFFF_FFFF;
        FpgaRdAddr = 4'd0;

        // Reset state, with a local request held to show reset blocks the grant.
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        check32("rst_state_skip", 32'(dut.state), 32'(SKIP));
        check32("rst_loc_gnt", 32'(LocWrGnt), 32'd0);
        check32("rst_frame_cnt", 32'(FrameCnt), 32'd0);
        check32("rst_err_cnt", 32'(ErrCnt), 32'd0);
        check32("rst_spi_wr_addr", 32'(SpiWrAddr), 32'd0);
        check32("rst_spi_wr_stb", 32'(SpiWrStb), 32'd0);
        check32("rst_data_to_rpi", DataToRPi, 32'd0);
        check32("rst_fpga_rd_data", FpgaRdData, 32'd0);
        check32("rst_wdog_trip", 32'(WdogTrip), 32'd0);
        @(posedge Clk);
        #1;
        Reset    = 1'b0;
        LocWrReq = 1'b0;
        read_check(4'd9, 32'd0, "rst_no_loc_write");

`ifdef SPI_REG_WDOG_EN
        begin
            int k;
            exp_q.push_back('{4'd1, 16'd1});
            spi_frame(8'h81, 32'h0000_0001, 40);
            loc_write(4'd0, 32'd5);
            read_check(4'd0, 32'd5, "wdog_bank0_before");
            check32("wdog_trip_low", 32'(WdogTrip), 32'd0);
            k = 0;
            @(negedge Clk);
            while (WdogTrip !== 1'b1 && k < 300) begin
                @(negedge Clk);
                k++;
            end
            check32("wdog_trip_set", 32'(WdogTrip), 32'd1);
            read_check(4'd0, 32'd0, "wdog_bank0_zeroed");
            read_check(4'd1, 32'd0, "wdog_bank1_zeroed");
            exp_q.push_back('{4'd10, 16'd2});
            spi_frame(8'h8A, 32'h0000_0077, 40);
            check32("wdog_trip_cleared", 32'(WdogTrip), 32'd0);
        end
`endif
        do_reset();

        // Good write frame.
        exp_q.push_back('{4'd3, 16'd1});
        spi_frame(8'h83, 32'hDEAD_BEEF, 40);
        read_check(4'd3, 32'hDEAD_BEEF, "wr83_bank3");
        check32("wr83_err_cnt", 32'(ErrCnt), 32'd0);

        // Short frame: CS rises after 24 bits.
        spi_frame(8'h85, 32'h1111_1111, 24);
        check32("short_err_cnt", 32'(ErrCnt), 32'd1);
        check32("short_frame_cnt", 32'(FrameCnt), 32'd1);
        read_check(4'd5, 32'd0, "short_bank5");

        // Write with reserved address bits set.
        spi_frame(8'hF2, 32'h2222_2222, 40);
        check32("badaddr_err_cnt", 32'(ErrCnt), 32'd2);
        check32("badaddr_frame_cnt", 32'(FrameCnt), 32'd1);
        read_check(4'd2, 32'd0, "badaddr_bank2");

        // Local write to index 2 raised during an SPI commit to index 2.
        LocWrAddr  = 4'd2;
        LocWrData  = 32'h5555_0002;
        FpgaRdAddr = 4'd2;
        exp_q.push_back('{4'd2, 16'd2});
        fork
            spi_frame(8'h82, 32'hAAAA_0002, 40);
            begin
                int k;
                k = 0;
                @(negedge Clk);
                while (dut.state != COMMIT && k < 2000) begin
                    @(negedge Clk);
                    k++;
                end
                check32("arb_commit_seen", 32'(dut.state), 32'(COMMIT));
                if (dut.state == COMMIT) begin
                    LocWrReq = 1'b1;
                    #1;
                    check32("arb_gnt_blocked", 32'(LocWrGnt), 32'd0);
                    @(negedge Clk);
                    check32("arb_gnt_next", 32'(LocWrGnt), 32'd1);
                    check32("arb_stb_with_gnt", 32'(SpiWrStb), 32'd1);
                    @(posedge Clk);
                    #1;
                    LocWrReq = 1'b0;
                    @(negedge Clk);
                    check32("arb_spi_first", FpgaRdData, 32'hAAAA_0002);
                    @(negedge Clk);
                    check32("arb_local_final", FpgaRdData, 32'h5555_0002);
                end
            end
        join

        // Same-cycle write and read of one index returns the old value first.
        loc_write(4'd7, 32'h1234_5678);
        read_check(4'd7, 32'h1234_5678, "loc_bank7");
        @(posedge Clk);
        #1;
        LocWrData = 32'h9ABC_DEF0;
        LocWrReq  = 1'b1;
        @(negedge Clk);
        check32("coll_gnt", 32'(LocWrGnt), 32'd1);
        @(posedge Clk);
        #1;
        LocWrReq = 1'b0;
        @(negedge Clk);
        check32("coll_old_value", FpgaRdData, 32'h1234_5678);
        @(negedge Clk);
        check32("coll_new_value", FpgaRdData, 32'h9ABC_DEF0);

        // Read frames; with the watchdog built in, bank[3] has been cleared by now.
        spi_frame(8'h03, 32'h0, 40);
        check32("rd03_frame_cnt", 32'(FrameCnt), 32'd3);
        check32("rd03_data_to_rpi", DataToRPi, WDOG_BUILD ? 32'd0 : 32'hDEAD_BEEF);
        spi_frame(8'h07, 32'h0, 40);
        check32("rd07_frame_cnt", 32'(FrameCnt), 32'd4);
        check32("rd07_data_to_rpi", DataToRPi, 32'h9ABC_DEF0);
        check32("rd_err_cnt", 32'(ErrCnt), 32'd2);

        // Reset in the middle of a frame with CS held low.
        @(posedge Clk);
        #1;
        DataAddr   = 8'h86;
        DataToFPGA = 32'h6666_6666;
        SPI_CS     = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        clk_bits(10);
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check32("midrst_state_skip", 32'(dut.state), 32'(SKIP));
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        clk_bits(30);
        @(negedge Clk);
        check32("midrst_still_skip", 32'(dut.state), 32'(SKIP));
        @(posedge Clk);
        #1;
        SPI_CS = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
        check32("midrst_frame_cnt", 32'(FrameCnt), 32'd0);
        check32("midrst_err_cnt", 32'(ErrCnt), 32'd0);
        read_check(4'd6, 32'd0, "midrst_bank6");
        exp_q.push_back('{4'd4, 16'd1});
        spi_frame(8'h84, 32'hCAFE_F00D, 40);
        read_check(4'd4, 32'hCAFE_F00D, "midrst_next_frame");

        repeat (4) @(posedge Clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drained: %0d writes pending, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
